// File: rtl/sync_int_pkg.sv
// Shared types and defaults for the sync-window sample integrator.
package sync_int_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    ACC
  } state_t;

  localparam logic MODE_SYNC  = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  localparam int DEF_DATA_W      = 24;
  localparam int DEF_ACC_W       = 48;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous strobe, followed by a registered
// rising-edge pulse. Pulse appears STAGES+1 cycles after the pin rises.
module sync_edge_det
  import sync_int_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_pulse
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= '0;
      last_q  <= 1'b0;
      o_pulse <= 1'b0;
    end else begin
      sync_q  <= (sync_q << 1) | STAGES'(i_async);
      last_q  <= sync_q[STAGES-1];
      o_pulse <= sync_q[STAGES-1] & ~last_q;
    end
  end

endmodule

// File: rtl/sync_sample_integrator.sv
// Integrate-and-dump of signed ADC samples over a sync-pin or 2^k window.
// Optional sync watchdog is built when SYNC_WDOG_EN is defined.
module sync_sample_integrator
  import sync_int_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic                     i_valid,
  input  logic                     i_sync,
  input  logic                     i_enable,
  input  logic                     i_mode,
  input  logic [3:0]               i_win_log2,
  input  logic                     i_clr_ovf,
  input  logic [31:0]              i_wdog_lim,
  output logic signed [ACC_W-1:0]  o_sum,
  output logic [CNT_W-1:0]         o_cnt,
  output logic signed [DATA_W-1:0] o_avg,
  output logic [15:0]              o_seq,
  output logic                     o_valid,
  output logic                     o_ovf,
  output logic                     o_busy,
  output logic                     o_sync_lost
);

  state_t                   state;
  logic                     mode_r;
  logic [3:0]               k_r;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         cnt;
  logic                     sync_evt;

  logic signed [ACC_W-1:0]  data_ext;
  logic signed [ACC_W-1:0]  sum_next;
  logic [CNT_W-1:0]         cnt_next;
  logic [CNT_W-1:0]         win_max;
  logic                     add_ovf;
  logic                     cnt_full;
  logic                     dump_fire;
  logic signed [ACC_W-1:0]  dump_sum;
  logic [CNT_W-1:0]         dump_cnt;
  logic signed [DATA_W-1:0] dump_avg;
  logic                     ovf_set;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_sync),
    .o_pulse (sync_evt)
  );

  assign data_ext = ACC_W'(i_data);
  assign sum_next = acc + data_ext;
  assign add_ovf  = (acc[ACC_W-1] == data_ext[ACC_W-1]) && (sum_next[ACC_W-1] != acc[ACC_W-1]);
  assign cnt_full = &cnt;
  assign cnt_next = cnt_full ? cnt : cnt + CNT_W'(1);
  assign win_max  = CNT_W'((32'd1 << k_r) - 32'd1);
  assign o_busy   = (state != IDLE);

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    dump_fire = 1'b0;
    dump_sum  = acc;
    dump_cnt  = cnt;
    dump_avg  = '0;
    ovf_set   = 1'b0;
    if (i_enable && state == ACC) begin
      if (mode_r == MODE_SYNC) begin
        // The closing sync window never includes the coincident sample.
        if (sync_evt) dump_fire = 1'b1;
        else if (i_valid) ovf_set = add_ovf | cnt_full;
      end else if (i_valid) begin
        ovf_set = add_ovf | cnt_full;
        if (cnt == win_max) begin
          dump_fire = 1'b1;
          dump_sum  = sum_next;
          dump_cnt  = cnt_next;
          dump_avg  = DATA_W'(sum_next >>> k_r);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      mode_r  <= MODE_SYNC;
      k_r     <= '0;
      acc     <= '0;
      cnt     <= '0;
      o_sum   <= '0;
      o_cnt   <= '0;
      o_avg   <= '0;
      o_seq   <= '0;
      o_valid <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments take the last write, so the set below beats the clear.
      o_valid <= dump_fire;
      if (i_clr_ovf) o_ovf <= 1'b0;
      if (ovf_set)   o_ovf <= 1'b1;

      if (dump_fire) begin
        o_sum <= dump_sum;
        o_cnt <= dump_cnt;
        o_avg <= dump_avg;
        o_seq <= o_seq + 16'd1;
      end

      if (!i_enable) begin
        state <= IDLE;
        acc   <= '0;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            acc    <= '0;
            cnt    <= '0;
            mode_r <= i_mode;
            k_r    <= i_win_log2;
            state  <= (i_mode == MODE_FIXED) ? ACC : ARM;
          end
          ARM: begin
            if (sync_evt) begin
              state <= ACC;
              acc   <= i_valid ? data_ext : '0;
              cnt   <= i_valid ? CNT_W'(1) : '0;
            end
          end
          ACC: begin
            if (mode_r == MODE_SYNC && sync_evt) begin
              acc <= i_valid ? data_ext : '0;
              cnt <= i_valid ? CNT_W'(1) : '0;
            end else if (dump_fire) begin
              acc <= '0;
              cnt <= '0;
            end else if (i_valid) begin
              acc <= sum_next;
              cnt <= cnt_next;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SYNC_WDOG_EN
  logic [31:0] wdog_cnt;
  logic        sync_lost;
  logic        wdog_run;

  assign wdog_run    = i_enable && (state == ARM || (state == ACC && mode_r == MODE_SYNC));
  assign o_sync_lost = sync_lost;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wdog_cnt  <= '0;
      sync_lost <= 1'b0;
    end else if (!wdog_run || sync_evt) begin
      wdog_cnt  <= '0;
      sync_lost <= 1'b0;
    end else if (!sync_lost && i_wdog_lim != 32'd0) begin
      // Counter freezes once the flag is raised; it only restarts on a sync edge.
      wdog_cnt <= wdog_cnt + 32'd1;
      if (wdog_cnt + 32'd1 == i_wdog_lim) sync_lost <= 1'b1;
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^i_wdog_lim;
  assign o_sync_lost = 1'b0;
`endif

endmodule

// File: tb/tb_sync_sample_integrator.sv
// Directed bench for sync_sample_integrator; watchdog steps run when SYNC_WDOG_EN is defined.
module tb_sync_sample_integrator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] data = '0;
  logic        valid = 1'b0;
  logic        sync = 1'b0;
  logic        enable = 1'b0;
  logic        enable2 = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  win_log2 = '0;
  logic        clr_ovf = 1'b0;
  logic [31:0] wdog_lim = '0;

  logic [47:0] sum;
  logic [15:0] cnt;
  logic [23:0] avg;
  logic [15:0] seq;
  logic        dvalid, ovf, busy, lost;

  logic [23:0] unused_sum2;
  logic [23:0] unused_avg2;
  logic [15:0] unused_seq2;
  logic [15:0] cnt2;
  logic        dvalid2, ovf2, unused_busy2, unused_lost2;

  int n_asserts = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sync_sample_integrator dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .i_sync(sync),
    .i_enable(enable), .i_mode(mode), .i_win_log2(win_log2), .i_clr_ovf(clr_ovf),
    .i_wdog_lim(wdog_lim), .o_sum(sum), .o_cnt(cnt), .o_avg(avg), .o_seq(seq),
    .o_valid(dvalid), .o_ovf(ovf), .o_busy(busy), .o_sync_lost(lost)
  );

  // Narrow accumulator instance, used to provoke signed overflow quickly.
  sync_sample_integrator #(.ACC_W(24)) dut_narrow (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .i_sync(sync),
    .i_enable(enable2), .i_mode(mode), .i_win_log2(win_log2), .i_clr_ovf(clr_ovf),
    .i_wdog_lim(wdog_lim), .o_sum(unused_sum2), .o_cnt(cnt2), .o_avg(unused_avg2),
    .o_seq(unused_seq2), .o_valid(dvalid2), .o_ovf(ovf2), .o_busy(unused_busy2),
    .o_sync_lost(unused_lost2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] d);
    data  = d;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  // Returns in the cycle where the synchronized pulse is high.
  task automatic sync_edge();
    sync = 1'b1;
    repeat (3) tick();
    sync = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_sum", sum, 0);
    check("rst_cnt", cnt, 0);
    check("rst_avg", avg, 0);
    check("rst_seq", seq, 0);
    check("rst_valid", dvalid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_lost", lost, 0);
    rst_n = 1'b1;
    tick();

    // Fixed window k=2; a k change mid-window must be ignored.
    mode = 1'b1; win_log2 = 4'd2; enable = 1'b1;
    tick();
    win_log2 = 4'd3;
    check("m1_busy", busy, 1);
    send(24'd10); send(24'hFFFFFC); send(24'd7);
    check("m1_no_early_valid", dvalid, 0);
    send(24'd3);
    check("m1_valid", dvalid, 1);
    check("m1_sum", sum, 48'd16);
    check("m1_cnt", cnt, 16'd4);
    check("m1_avg", avg, 24'd4);
    check("m1_seq", seq, 16'd1);
    tick();
    check("m1_valid_pulse", dvalid, 0);

    // Negative mean rounds toward minus infinity: -5 >>> 1 = -3.
    enable = 1'b0; tick();
    win_log2 = 4'd1; enable = 1'b1; tick();
    send(24'hFFFFFD); send(24'hFFFFFE);
    check("neg_sum", sum, 48'hFFFF_FFFF_FFFB);
    check("neg_avg", avg, 24'hFFFFFD);
    check("neg_seq", seq, 16'd2);

    // Sync window: ARM discards samples, coincident sample seeds next window.
    enable = 1'b0; tick();
    check("idle_busy", busy, 0);
    mode = 1'b0; enable = 1'b1; tick();
    check("arm_busy", busy, 1);
    send(24'd50);
    sync_edge(); tick();
    repeat (5) send(24'd100);
    tick(); tick();
    sync_edge();
    data = 24'd7; valid = 1'b1;
    tick();
    valid = 1'b0;
    check("m0_valid", dvalid, 1);
    check("m0_sum", sum, 48'd500);
    check("m0_cnt", cnt, 16'd5);
    check("m0_avg", avg, 24'd0);
    check("m0_seq", seq, 16'd3);
    tick(); tick();
    sync_edge(); tick();
    check("m0_seed_valid", dvalid, 1);
    check("m0_seed_sum", sum, 48'd7);
    check("m0_seed_cnt", cnt, 16'd1);
    tick(); tick();
    sync_edge(); tick();
    check("m0_empty_valid", dvalid, 1);
    check("m0_empty_sum", sum, 48'd0);
    check("m0_empty_cnt", cnt, 16'd0);
    check("m0_empty_seq", seq, 16'd5);

    // Largest fixed window with full-scale positive samples.
    enable = 1'b0; tick();
    mode = 1'b1; win_log2 = 4'd15; enable = 1'b1; tick();
    data = 24'h7FFFFF; valid = 1'b1;
    repeat (32767) tick();
    check("k15_no_early_valid", dvalid, 0);
    tick();
    valid = 1'b0;
    check("k15_valid", dvalid, 1);
    check("k15_sum", sum, 48'h003F_FFFF_8000);
    check("k15_cnt", cnt, 16'h8000);
    check("k15_avg", avg, 24'h7FFFFF);
    check("k15_ovf", ovf, 0);
    check("k15_seq", seq, 16'd6);

    // Enable drop discards the partial window; outputs hold.
    enable = 1'b0; tick();
    win_log2 = 4'd2; enable = 1'b1; tick();
    send(24'd5); send(24'd6);
    enable = 1'b0;
    tick();
    check("drop_busy", busy, 0);
    check("drop_valid", dvalid, 0);
    check("drop_sum_hold", sum, 48'h003F_FFFF_8000);
    check("drop_seq_hold", seq, 16'd6);
    tick();
    win_log2 = 4'd1; enable = 1'b1; tick();
    send(24'd1); send(24'd2);
    check("reen_valid", dvalid, 1);
    check("reen_sum", sum, 48'd3);
    check("reen_cnt", cnt, 16'd2);
    check("reen_avg", avg, 24'd1);
    check("reen_seq", seq, 16'd7);

    // Signed overflow on the 24-bit accumulator, clear, and set-beats-clear.
    enable = 1'b0; tick();
    win_log2 = 4'd1; enable2 = 1'b1; tick();
    send(24'h7FFFFF); send(24'h7FFFFF);
    check("ovf_valid", dvalid2, 1);
    check("ovf_cnt", cnt2, 16'd2);
    check("ovf_set", ovf2, 1);
    check("ovf_main_clean", ovf, 0);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("ovf_clr", ovf2, 0);
    send(24'h7FFFFF);
    clr_ovf = 1'b1;
    send(24'h7FFFFF);
    clr_ovf = 1'b0;
    check("ovf_set_wins", ovf2, 1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("ovf_clr2", ovf2, 0);
    enable2 = 1'b0; tick();

`ifdef SYNC_WDOG_EN
    mode = 1'b0; wdog_lim = 32'd1000; enable = 1'b1; tick();
    repeat (999) tick();
    check("wdog_before_lim", lost, 0);
    tick();
    check("wdog_at_lim", lost, 1);
    repeat (5) tick();
    check("wdog_sticky", lost, 1);
    sync_edge(); tick();
    check("wdog_cleared", lost, 0);
    enable = 1'b0; tick();
`else
    mode = 1'b0; wdog_lim = 32'd10; enable = 1'b1; tick();
    repeat (20) tick();
    check("wdog_tied_low", lost, 0);
    enable = 1'b0; tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
